// File: rtl/iob_cpu_bus_split_pkg.sv
// Shared types and constants for the CPU-to-IOb bus splitter.
package iob_cpu_bus_split_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RWAIT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte-strobe width for a given data width.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Read data returned on a timeout abort; sliced to DATA_W by users.
  localparam logic [1023:0] ERR_DATA = '1;

endpackage

// File: rtl/iob_cpu_bus_timer.sv
// Saturating bus-timeout counter. Clear has priority over enable; the
// expired flag is only raised while the counter is enabled, so a stale
// count left over after an abort never leaks into the next transaction.
// TIMEOUT_CYC must fit in TIMEOUT_W bits; 0 removes the counter entirely.
module iob_cpu_bus_timer #(
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic cke_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, clk_i, arst_n_i, cke_i, clr_i, en_i};
      assign expired_o = 1'b0;
    end else begin : g_on
      localparam logic [TIMEOUT_W-1:0] LP_LIMIT = TIMEOUT_W'(TIMEOUT_CYC);
      logic [TIMEOUT_W-1:0] r_cnt;

      // Count enabled cycles, stopping at all-ones instead of wrapping.
      always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
          r_cnt <= '0;
        end else if (cke_i) begin
          if (clr_i) begin
            r_cnt <= '0;
          end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign expired_o = en_i && (r_cnt == LP_LIMIT);
    end
  endgenerate

endmodule

// File: rtl/iob_cpu_bus_split.sv
// Splits a PicoRV32-style native memory port onto an instruction and a data
// IOb manager bus. One CPU access produces exactly one IOb request; reads
// wait for rvalid, writes complete on acceptance, and a stalled access is
// aborted by the timer with all-ones data and an error pulse.
module iob_cpu_bus_split
  import iob_cpu_bus_split_pkg::*;
#(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int USE_EXTMEM  = 0,
  parameter  int TIMEOUT_W   = 8,
  parameter  int TIMEOUT_CYC = 255,
  localparam int STRB_W      = strb_w(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              boot_i,
  input  logic              cpu_valid_i,
  input  logic              cpu_instr_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [STRB_W-1:0] cpu_wstrb_i,
  output logic              cpu_ready_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_err_o,
  output logic              ibus_avalid_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  output logic [DATA_W-1:0] ibus_wdata_o,
  output logic [STRB_W-1:0] ibus_wstrb_o,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  input  logic              ibus_rvalid_i,
  input  logic              ibus_ready_i,
  output logic              dbus_avalid_o,
  output logic [ADDR_W-1:0] dbus_addr_o,
  output logic [DATA_W-1:0] dbus_wdata_o,
  output logic [STRB_W-1:0] dbus_wstrb_o,
  input  logic [DATA_W-1:0] dbus_rdata_i,
  input  logic              dbus_rvalid_i,
  input  logic              dbus_ready_i
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_sel_ibus;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_start;
  logic              w_busy;
  logic              w_expired;
  logic              w_issue;
  logic              w_is_write;
  logic              w_sel_ready;
  logic              w_sel_rvalid;
  logic [DATA_W-1:0] w_sel_rdata;
  logic              w_addr_msb;
  logic [ADDR_W-1:0] w_addr_remap;
  logic              w_ib_act;
  logic              w_db_act;

  assign w_start      = (r_state == ST_IDLE) && cpu_valid_i;
  assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_RWAIT);
  // An expired request is withdrawn in the same cycle so it cannot be
  // accepted after the CPU has already been told it failed.
  assign w_issue      = (r_state == ST_ISSUE) && !w_expired;
  assign w_is_write   = |r_wstrb;
  assign w_sel_ready  = r_sel_ibus ? ibus_ready_i  : dbus_ready_i;
  assign w_sel_rvalid = r_sel_ibus ? ibus_rvalid_i : dbus_rvalid_i;
  assign w_sel_rdata  = r_sel_ibus ? ibus_rdata_i  : dbus_rdata_i;

  // Boot remap of the address MSB, evaluated on the value being latched.
  always_comb begin
    w_addr_msb = 1'b0;
    if (USE_EXTMEM != 0) begin
      w_addr_msb = cpu_instr_i ? ~boot_i : cpu_addr_i[ADDR_W-1];
    end
    w_addr_remap = {w_addr_msb, cpu_addr_i[ADDR_W-2:0]};
  end

  iob_cpu_bus_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .cke_i    (cke_i),
    .clr_i    (w_start),
    .en_i     (w_busy),
    .expired_o(w_expired)
  );

  // Next-state decode; rvalid is checked before the timeout so it wins a tie.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (cpu_valid_i) w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        if (w_expired) begin
          w_state_next = ST_DONE;
        end else if (w_sel_ready) begin
          w_state_next = w_is_write ? ST_DONE : ST_RWAIT;
        end
      end
      ST_RWAIT: if (w_sel_rvalid || w_expired) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register, frozen while the clock enable is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_next;
    end
  end

  // Request latch and response capture.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_sel_ibus <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else if (cke_i) begin
      if (w_start) begin
        r_sel_ibus <= cpu_instr_i;
        r_addr     <= w_addr_remap;
        r_wdata    <= cpu_wdata_i;
        r_wstrb    <= cpu_wstrb_i;
        r_rdata    <= '0;
        r_err      <= 1'b0;
      end else if ((r_state == ST_RWAIT) && w_sel_rvalid) begin
        r_rdata <= w_sel_rdata;
      end else if (w_busy && w_expired) begin
        r_rdata <= ERR_DATA[DATA_W-1:0];
        r_err   <= 1'b1;
      end
    end
  end

  assign w_ib_act = w_issue && r_sel_ibus;
  assign w_db_act = w_issue && !r_sel_ibus;

  assign ibus_avalid_o = w_ib_act;
  assign ibus_addr_o   = w_ib_act ? r_addr  : '0;
  assign ibus_wdata_o  = w_ib_act ? r_wdata : '0;
  assign ibus_wstrb_o  = w_ib_act ? r_wstrb : '0;

  assign dbus_avalid_o = w_db_act;
  assign dbus_addr_o   = w_db_act ? r_addr  : '0;
  assign dbus_wdata_o  = w_db_act ? r_wdata : '0;
  assign dbus_wstrb_o  = w_db_act ? r_wstrb : '0;

  assign cpu_ready_o = (r_state == ST_DONE);
  assign cpu_rdata_o = cpu_ready_o ? r_rdata : '0;
  assign cpu_err_o   = cpu_ready_o && r_err;

endmodule

// File: tb/tb_iob_cpu_bus_split.sv
// Directed bench for iob_cpu_bus_split. Instance a: USE_EXTMEM=1, long
// timeout. Instance b: USE_EXTMEM=0, TIMEOUT_CYC=4. Completions are
// checked against a scoreboard filled when each request is issued.
module tb_iob_cpu_bus_split;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cke = 1'b1;
  logic        boot = 1'b0;
  logic        valid_a = 1'b0;
  logic        valid_b = 1'b0;
  logic        instr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] ib_rdata = '0;
  logic        ib_rvalid = 1'b0;
  logic        ib_ready = 1'b0;
  logic [31:0] db_rdata = '0;
  logic        db_rvalid = 1'b0;
  logic        db_ready = 1'b0;

  logic        a_rdy, a_err, a_ib_av, a_db_av;
  logic [31:0] a_rd, a_ib_addr, a_ib_wd, a_db_addr, a_db_wd;
  logic [3:0]  a_ib_ws, a_db_ws;
  logic        b_rdy, b_err, b_ib_av, b_db_av;
  logic [31:0] b_rd, b_ib_addr, b_ib_wd, b_db_addr, b_db_wd;
  logic [3:0]  b_ib_ws, b_db_ws;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iob_cpu_bus_split #(.ADDR_W(32), .DATA_W(32), .USE_EXTMEM(1), .TIMEOUT_W(8), .TIMEOUT_CYC(255)) dut_a (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .boot_i(boot),
    .cpu_valid_i(valid_a), .cpu_instr_i(instr), .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_wstrb_i(wstrb),
    .cpu_ready_o(a_rdy), .cpu_rdata_o(a_rd), .cpu_err_o(a_err),
    .ibus_avalid_o(a_ib_av), .ibus_addr_o(a_ib_addr), .ibus_wdata_o(a_ib_wd), .ibus_wstrb_o(a_ib_ws),
    .ibus_rdata_i(ib_rdata), .ibus_rvalid_i(ib_rvalid), .ibus_ready_i(ib_ready),
    .dbus_avalid_o(a_db_av), .dbus_addr_o(a_db_addr), .dbus_wdata_o(a_db_wd), .dbus_wstrb_o(a_db_ws),
    .dbus_rdata_i(db_rdata), .dbus_rvalid_i(db_rvalid), .dbus_ready_i(db_ready)
  );

  iob_cpu_bus_split #(.ADDR_W(32), .DATA_W(32), .USE_EXTMEM(0), .TIMEOUT_W(8), .TIMEOUT_CYC(4)) dut_b (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .boot_i(boot),
    .cpu_valid_i(valid_b), .cpu_instr_i(instr), .cpu_addr_i(addr), .cpu_wdata_i(wdata), .cpu_wstrb_i(wstrb),
    .cpu_ready_o(b_rdy), .cpu_rdata_o(b_rd), .cpu_err_o(b_err),
    .ibus_avalid_o(b_ib_av), .ibus_addr_o(b_ib_addr), .ibus_wdata_o(b_ib_wd), .ibus_wstrb_o(b_ib_ws),
    .ibus_rdata_i(ib_rdata), .ibus_rvalid_i(ib_rvalid), .ibus_ready_i(ib_ready),
    .dbus_avalid_o(b_db_av), .dbus_addr_o(b_db_addr), .dbus_wdata_o(b_db_wd), .dbus_wstrb_o(b_db_ws),
    .dbus_rdata_i(db_rdata), .dbus_rvalid_i(db_rvalid), .dbus_ready_i(db_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the oldest expected completion and compares it with the DUT output.
  task automatic expect_done(input string tag, input logic rdy, input logic [31:0] rd, input logic er);
    exp_t e;
    chk({tag, "_ready"}, 64'(rdy), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(rd), 64'(e.data));
      chk({tag, "_err"}, 64'(er), 64'(e.err));
      $display("txn %s rdata=%08h err=%0b", tag, rd, er);
    end
  endtask

  task automatic bus_idle();
    ib_ready = 1'b0; ib_rvalid = 1'b0; ib_rdata = '0;
    db_ready = 1'b0; db_rvalid = 1'b0; db_rdata = '0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_a_ctl", 64'({a_rdy, a_err, a_ib_av, a_db_av}), 64'd0);
    chk("rst_a_data", 64'({a_rd, a_ib_addr}), 64'd0);
    chk("rst_a_dbus", 64'({a_db_addr, a_db_wd}), 64'd0);
    chk("rst_b_ctl", 64'({b_rdy, b_err, b_ib_av, b_db_av}), 64'd0);
    rst_n = 1'b1;
    tick();

    // dbus write, ready held high
    db_ready = 1'b1;
    valid_a = 1'b1; instr = 1'b0; addr = 32'h100; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    sb.push_back('{data: 32'h0, err: 1'b0});
    tick();
    valid_a = 1'b0; addr = 32'hFFFF_FFFF; wdata = '0; wstrb = '0;
    chk("wr_c1_avalid", 64'(a_db_av), 64'd1);
    chk("wr_c1_addr", 64'(a_db_addr), 64'h100);
    chk("wr_c1_wdata", 64'(a_db_wd), 64'hDEADBEEF);
    chk("wr_c1_wstrb", 64'(a_db_ws), 64'hF);
    chk("wr_c1_ibus_idle", 64'({a_ib_av, a_ib_addr, a_ib_wd}), 64'd0);
    chk("wr_c1_ready", 64'(a_rdy), 64'd0);
    tick();
    chk("wr_c2_avalid", 64'(a_db_av), 64'd0);
    expect_done("wr", a_rdy, a_rd, a_err);
    tick();
    chk("wr_c3_ready", 64'(a_rdy), 64'd0);
    bus_idle();

    // ibus read with boot remap, ready low for three cycles
    boot = 1'b0;
    valid_a = 1'b1; instr = 1'b1; addr = 32'h0000_0040; wstrb = 4'h0;
    sb.push_back('{data: 32'h12345678, err: 1'b0});
    tick();
    valid_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd_avalid_c%0d", i + 1), 64'(a_ib_av), 64'd1);
      chk($sformatf("rd_addr_c%0d", i + 1), 64'(a_ib_addr), 64'h8000_0040);
      if (i == 3) ib_ready = 1'b1;
      tick();
    end
    ib_ready = 1'b0; ib_rdata = 32'hA5A5A5A5;
    chk("rd_c5_avalid", 64'(a_ib_av), 64'd0);
    chk("rd_c5_ready", 64'(a_rdy), 64'd0);
    tick();
    ib_rvalid = 1'b1; ib_rdata = 32'h12345678;
    chk("rd_c6_ready", 64'(a_rdy), 64'd0);
    tick();
    ib_rvalid = 1'b0;
    expect_done("rd", a_rdy, a_rd, a_err);
    chk("rd_dbus_idle", 64'(a_db_av), 64'd0);
    tick();
    bus_idle();

    // Timeout abort on instance b, MSB forced to 0
    valid_b = 1'b1; instr = 1'b0; addr = 32'h8000_0200; wstrb = 4'h0;
    sb.push_back('{data: 32'hFFFF_FFFF, err: 1'b1});
    tick();
    valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_avalid_c%0d", i + 1), 64'(b_db_av), 64'd1);
      chk($sformatf("to_addr_c%0d", i + 1), 64'(b_db_addr), 64'h0000_0200);
      tick();
    end
    chk("to_c5_avalid", 64'(b_db_av), 64'd0);
    chk("to_c5_ready", 64'(b_rdy), 64'd0);
    tick();
    expect_done("to", b_rdy, b_rd, b_err);
    tick();
    db_ready = 1'b1;
    valid_b = 1'b1; addr = 32'h204; wdata = 32'h11223344; wstrb = 4'h1;
    sb.push_back('{data: 32'h0, err: 1'b0});
    tick();
    valid_b = 1'b0;
    chk("to_next_avalid", 64'(b_db_av), 64'd1);
    tick();
    expect_done("to_next", b_rdy, b_rd, b_err);
    tick();
    bus_idle();

    // rvalid coinciding with the timeout cycle: rvalid wins
    db_ready = 1'b1;
    valid_b = 1'b1; addr = 32'h208; wstrb = 4'h0;
    sb.push_back('{data: 32'h0F0F0F0F, err: 1'b0});
    tick();
    valid_b = 1'b0;
    tick();
    db_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tie_wait_c%0d", i + 2), 64'(b_rdy), 64'd0);
      tick();
    end
    db_rvalid = 1'b1; db_rdata = 32'h0F0F0F0F;
    tick();
    db_rvalid = 1'b0;
    expect_done("tie", b_rdy, b_rd, b_err);
    tick();
    bus_idle();

    // Spurious rvalids in IDLE and on the unselected bus
    ib_rvalid = 1'b1; ib_rdata = 32'h0BAD0BAD; db_rvalid = 1'b1; db_rdata = 32'h0BAD0BAD;
    tick();
    chk("spur_idle_ready", 64'(a_rdy), 64'd0);
    db_rvalid = 1'b0;
    db_ready = 1'b1;
    valid_a = 1'b1; instr = 1'b0; addr = 32'h300; wstrb = 4'h0;
    sb.push_back('{data: 32'hCAFEF00D, err: 1'b0});
    tick();
    valid_a = 1'b0;
    chk("spur_avalid", 64'(a_db_av), 64'd1);
    tick();
    db_ready = 1'b0;
    chk("spur_rwait1_ready", 64'(a_rdy), 64'd0);
    tick();
    chk("spur_rwait2_ready", 64'(a_rdy), 64'd0);
    db_rvalid = 1'b1; db_rdata = 32'hCAFEF00D;
    tick();
    db_rvalid = 1'b0; ib_rvalid = 1'b0;
    expect_done("spur", a_rdy, a_rd, a_err);
    tick();
    bus_idle();

    // Asynchronous reset during ISSUE drops avalid immediately
    valid_a = 1'b1; instr = 1'b1; addr = 32'h44; wstrb = 4'h0;
    tick();
    valid_a = 1'b0;
    chk("arst_issue_pre", 64'(a_ib_av), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_issue_av", 64'({a_ib_av, a_ib_addr}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Asynchronous reset during RWAIT, late rvalid ignored
    ib_ready = 1'b1;
    valid_a = 1'b1; instr = 1'b1; addr = 32'h48; wstrb = 4'h0;
    tick();
    valid_a = 1'b0;
    tick();
    ib_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rwait_out", 64'({a_rdy, a_err, a_rd}), 64'd0);
    tick();
    rst_n = 1'b1;
    ib_rvalid = 1'b1; ib_rdata = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("arst_late_rvalid_%0d", i), 64'(a_rdy), 64'd0);
    end
    bus_idle();
    tick();

    // Clock enable low mid-ISSUE with ready high
    valid_a = 1'b1; instr = 1'b0; addr = 32'h400; wdata = 32'h0BADF00D; wstrb = 4'h3;
    sb.push_back('{data: 32'h0, err: 1'b0});
    tick();
    valid_a = 1'b0;
    chk("cke_c1_avalid", 64'(a_db_av), 64'd1);
    cke = 1'b0; db_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("cke_frozen_av_%0d", i), 64'(a_db_av), 64'd1);
      chk($sformatf("cke_frozen_rdy_%0d", i), 64'(a_rdy), 64'd0);
    end
    cke = 1'b1;
    tick();
    chk("cke_accept_av", 64'(a_db_av), 64'd0);
    expect_done("cke", a_rdy, a_rd, a_err);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("cke_once_%0d", i), 64'({a_rdy, a_db_av}), 64'd0);
    end
    bus_idle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iob_cpu_bus_split.md
# iob_cpu_bus_split

Parametrised adapter between a PicoRV32-style native memory port and two IOb native manager buses: instruction (ibus) and data (dbus). Each CPU access becomes exactly one single-cycle-accepted IOb request, with write-ack generation, boot-time address remapping and a bus-timeout abort. It sits between the CPU core and the system interconnect. Over the previous wrapper it adds configurable widths, registered request outputs, explicit handshake sequencing and timeout/error reporting.

## Interface
- ADDR_W, 32: address width of CPU and both buses
- DATA_W, 32: data width; wstrb width is DATA_W/8
- USE_EXTMEM, 0: 1 → ibus address MSB = ~boot_i; dbus MSB passes through. 0 → both MSBs forced 0
- TIMEOUT_W, 8: timeout counter width
- TIMEOUT_CYC, 255: cycles without completion before abort; 0 disables timeout

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  reset; one clock; asynchronous, active-low
- cke_i  in  1  clock enable; low freezes all state
- boot_i  in  1  boot mode (used only when USE_EXTMEM=1)
- cpu_valid_i / cpu_instr_i  in  1 / 1  CPU request; instruction-fetch flag
- cpu_addr_i / cpu_wdata_i / cpu_wstrb_i  in  ADDR_W / DATA_W / DATA_W/8  request fields; wstrb≠0 means write
- cpu_ready_o  out  1  one-cycle completion pulse
- cpu_rdata_o  out  DATA_W  read data, valid with cpu_ready_o
- cpu_err_o  out  1  pulses with cpu_ready_o on timeout abort
- ibus_avalid_o / ibus_addr_o / ibus_wdata_o / ibus_wstrb_o  out  1 / ADDR_W / DATA_W / DATA_W/8  ibus request
- ibus_rdata_i / ibus_rvalid_i / ibus_ready_i  in  DATA_W / 1 / 1  ibus response
- dbus_*  same set as ibus_*  data bus

## Operation
- FSM states IDLE, ISSUE, RWAIT, DONE.
- IDLE: on cpu_valid_i, latch addr/wdata/wstrb/instr, select bus (instr→ibus, else dbus), go to ISSUE.
- ISSUE: selected avalid_o=1 with registered fields; unselected bus sees avalid 0 and all fields 0.
  - On ready_i=1: avalid drops next cycle.
  - Write: go to DONE.
  - Read: go to RWAIT.
- RWAIT: on selected rvalid_i, capture rdata, go to DONE. rvalid on the unselected bus, or in any other state, is ignored.
- DONE: cpu_ready_o=1 for one cycle (cpu_rdata_o = captured data on reads, 0 on writes), then IDLE.
- Address MSB remap is applied to the registered address per USE_EXTMEM.
- Timeout:
  - Counter clears on IDLE→ISSUE and increments each enabled cycle in ISSUE/RWAIT.
  - At count==TIMEOUT_CYC: drop avalid, go to DONE with cpu_rdata_o all-ones and cpu_err_o=1.
  - The counter saturates and never wraps.
- Reset (async, any state): state IDLE, counter 0, all latched fields 0. A mid-transaction reset abandons the bus transaction silently, with no cpu_ready_o.

## Timing
- Reset values: all outputs 0.
- Minimum latencies, with c0 = cpu_valid_i sampled in IDLE:
  - Write: avalid at c1, accepted at c1 if ready_i=1, cpu_ready_o at c2.
  - Read: avalid at c1, rvalid at c2, cpu_ready_o at c3.
- avalid is high for exactly one cycle when ready_i is already high; otherwise it holds until the ready cycle (inclusive).
- cpu_valid_i deasserting while not in IDLE has no effect; the transaction completes.
- A new request is accepted in the cycle after DONE.
- cke_i=0 freezes state, counter and outputs; a stuck-high ready_i/rvalid_i is not consumed twice.
- Simultaneous rvalid_i and timeout in the same cycle: rvalid wins, normal completion, no err.

## Structure
- Package iob_cpu_bus_split_pkg holds:
  - state enum (2-bit)
  - STRB_W = DATA_W/8 as a localparam function
  - all-ones error data constant
- Sub-module iob_cpu_bus_timer: TIMEOUT_W saturating counter with clear/enable/expired outputs; tied off when TIMEOUT_CYC=0.
- FSM, request registers and bus muxing stay in the top module.

## Test plan
- dbus write, addr 0x100, wdata 0xDEADBEEF, wstrb 0xF, ready_i held 1 → dbus avalid one cycle at c1 with those fields; cpu_ready_o at c2; ibus stays idle.
- ibus read, USE_EXTMEM=1, boot_i=0, addr 0x0000_0040, ready low 3 cycles, rvalid 2 cycles after accept with 0x12345678 → ibus_addr_o=0x8000_0040; avalid 4 cycles; cpu_rdata_o=0x12345678 one cycle after rvalid.
- TIMEOUT_CYC=4, dbus read, ready_i stuck 0 → abort after 4 ISSUE cycles; cpu_ready_o=cpu_err_o=1 with rdata 0xFFFFFFFF; next request handled normally.
- Spurious ibus_rvalid_i during a dbus read, plus rvalid in IDLE → ignored; dbus completes with dbus data.
- arst_n_i pulsed low during RWAIT → all outputs 0 immediately; no cpu_ready_o; a late rvalid after reset is ignored.
- cke_i=0 for 5 cycles mid-ISSUE with ready_i=1 → no progress; after cke_i=1, acceptance and completion happen once.
